// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter int BW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*BW-1:0] req_a,
    input  logic [2*BW-1:0] req_b,
    input  logic [7:0]      req_opcode,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [BW-1:0]   rsp_data,
    output logic [2:0]      rsp_flags,
    output logic            rsp_err,
    output logic [BW-1:0]   alu_a,
    output logic [BW-1:0]   alu_b,
    output logic [3:0]      alu_opcode,
    input  logic [BW-1:0]   alu_out,
    input  logic [2:0]      alu_flags,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gid_q, gid_d;
    logic [BW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [BW-1:0]   data_q, data_d;
    logic [2:0]      flags_q, flags_d;
    logic            err_q, err_d;
    logic            gnt_id;

    // On a tie the pointer decides; otherwise the single valid requester wins.
    always_comb begin
        gnt_id = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        data_d    = data_q;
        flags_d   = flags_q;
        err_d     = err_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // Ready is masked while reset is held so every output reads zero.
                    req_ready[gnt_id] = ~rst;
                    state_d = EXEC;
                    ptr_d   = ~gnt_id;
                    gid_d   = gnt_id;
                    a_d     = gnt_id ? req_a[2*BW-1:BW] : req_a[BW-1:0];
                    b_d     = gnt_id ? req_b[2*BW-1:BW] : req_b[BW-1:0];
                    op_d    = gnt_id ? req_opcode[7:4] : req_opcode[3:0];
                end
            end
            EXEC: begin
                state_d = RESP;
                if (op_q[3]) begin
                    data_d  = '0;
                    flags_d = 3'b000;
                    err_d   = 1'b1;
                end else begin
                    data_d  = alu_out;
                    flags_d = alu_flags;
                    err_d   = 1'b0;
                end
            end
            RESP: begin
                rsp_valid[gid_q] = 1'b1;
                if (rsp_ready[gid_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 4'd0;
            data_q  <= '0;
            flags_q <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign rsp_data   = data_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbitration model
module tb_alu_arbiter;

    localparam int BW = 16;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_MOVB = 4'd7;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*BW-1:0] req_a;
    logic [2*BW-1:0] req_b;
    logic [7:0]      req_opcode;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [BW-1:0]   rsp_data;
    logic [2:0]      rsp_flags;
    logic            rsp_err;
    logic [BW-1:0]   alu_a;
    logic [BW-1:0]   alu_b;
    logic [3:0]      alu_opcode;
    logic [BW-1:0]   alu_out;
    logic [2:0]      alu_flags;
    logic            busy;

    int   n_checks = 0;
    int   n_err = 0;
    logic pref = 1'b0;

    logic [15:0] od;
    logic [2:0]  of_;
    logic        oe;

    alu_arbiter #(.BW(BW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached ALU: returns {overflow, negative, zero, result}; illegal opcodes give junk.
    function automatic logic [18:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            4'd0: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a + 16'd1; ov = (a == 16'h7FFF); end
            4'd6: r = a;
            4'd7: r = b;
            default: begin r = 16'hDEAD; ov = 1'b1; end
        endcase
        return {ov, r[15], (r == 16'd0), r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_ref(alu_opcode, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_rsp_flags"}, 32'(rsp_flags), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_alu_a"}, 32'(alu_a), 0);
        chk({tag, "_alu_b"}, 32'(alu_b), 0);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic new_req(input logic idx);
        if (idx) begin
            req_a[31:16]     = 16'($urandom);
            req_b[31:16]     = 16'($urandom);
            req_opcode[7:4]  = 4'($urandom_range(0, 15));
        end else begin
            req_a[15:0]      = 16'($urandom);
            req_b[15:0]      = 16'($urandom);
            req_opcode[3:0]  = 4'($urandom_range(0, 15));
        end
    endtask

    // Runs one operation from IDLE to the next IDLE. mode: 0 hold inputs, 1 apply given
    // inputs during EXEC, 2 randomise the granted requester during EXEC.
    task automatic expect_op(input int rdelay, input int mode,
                             input logic [1:0] nv, input logic [31:0] na, input logic [31:0] nb,
                             input logic [7:0] nop,
                             output logic [15:0] o_d, output logic [2:0] o_f, output logic o_e);
        logic        gid;
        logic [1:0]  oh;
        logic [15:0] ea, eb;
        logic [3:0]  eop;
        logic        eerr;
        logic [18:0] ex;
        gid  = (req_valid == 2'b11) ? pref : req_valid[1];
        oh   = gid ? 2'b10 : 2'b01;
        ea   = gid ? req_a[31:16] : req_a[15:0];
        eb   = gid ? req_b[31:16] : req_b[15:0];
        eop  = gid ? req_opcode[7:4] : req_opcode[3:0];
        eerr = eop[3];
        ex   = eerr ? 19'd0 : alu_ref(eop, ea, eb);
        o_d = 16'd0; o_f = 3'd0; o_e = 1'b0;
        #1;
        chk("grant_ready", 32'(req_ready), 32'(oh));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        pref = ~gid;
        @(negedge clk);
        if (mode == 1) begin
            req_valid = nv; req_a = na; req_b = nb; req_opcode = nop;
        end else if (mode == 2) begin
            new_req(gid);
            req_valid[gid] = 1'($urandom_range(0, 1));
            if (!req_valid[~gid] && $urandom_range(0, 1) == 1) begin
                new_req(~gid);
                req_valid[~gid] = 1'b1;
            end
        end
        #1;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        chk("exec_req_ready", 32'(req_ready), 0);
        chk("exec_alu_a", 32'(alu_a), 32'(ea));
        chk("exec_alu_b", 32'(alu_b), 32'(eb));
        chk("exec_alu_opcode", 32'(alu_opcode), 32'(eop));
        @(negedge clk);
        for (int d = 0; d <= rdelay; d++) begin
            rsp_ready = (d == rdelay) ? oh : 2'b00;
            rsp_ready[~gid] = 1'($urandom_range(0, 1));
            #1;
            chk("rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("rsp_data", 32'(rsp_data), 32'(ex[15:0]));
            chk("rsp_flags", 32'(rsp_flags), 32'(ex[18:16]));
            chk("rsp_err", 32'(rsp_err), 32'(eerr));
            chk("rsp_busy", 32'(busy), 1);
            chk("rsp_req_ready", 32'(req_ready), 0);
            o_d = rsp_data; o_f = rsp_flags; o_e = rsp_err;
            @(negedge clk);
        end
        rsp_ready = 2'b00;
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_busy", 32'(busy), 0);
    endtask

    task automatic reset_in_exec(input logic idx, input logic [15:0] a, input logic [3:0] op, input string tag);
        req_valid = idx ? 2'b10 : 2'b01;
        if (idx) begin
            req_a[31:16] = a; req_b[31:16] = 16'd0; req_opcode[7:4] = op;
        end else begin
            req_a[15:0] = a; req_b[15:0] = 16'd0; req_opcode[3:0] = op;
        end
        #1;
        chk({tag, "_ready"}, 32'(req_ready), idx ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_exec_busy"}, 32'(busy), 1);
        chk({tag, "_exec_alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_exec_alu_op"}, 32'(alu_opcode), 32'(op));
        #1;
        req_valid = 2'b11;
        rst = 1'b1;
        pref = 1'b0;
        #1;
        reset_checks(tag);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk({tag, "_after_rsp_valid"}, 32'(rsp_valid), 0);
            chk({tag, "_after_busy"}, 32'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        req_opcode = 8'd0;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester ADD with signed overflow.
        req_valid = 2'b01;
        req_a = {16'd0, 16'h7FFF}; req_b = {16'd0, 16'h7FFF}; req_opcode = {4'd0, OP_ADD};
        expect_op(0, 1, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);
        chk("add_data", 32'(od), 32'hFFFE);
        chk("add_flags", 32'(of_), 32'b110);
        chk("add_err", 32'(oe), 0);

        @(negedge clk);
        rst = 1'b1;
        pref = 1'b0;
        #1;
        reset_checks("reset2");
        @(negedge clk);
        rst = 1'b0;

        // Both requesters valid: req0, req1, req0.
        req_valid = 2'b11;
        req_a = {16'h0000, 16'h8000}; req_b = {16'h0000, 16'h7FFF}; req_opcode = {OP_ADD, OP_SUB};
        expect_op(0, 0, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);
        chk("rr_sub_data", 32'(od), 32'h0001);
        chk("rr_sub_flags", 32'(of_), 32'b100);
        expect_op(0, 0, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);
        chk("rr_add0_data", 32'(od), 0);
        chk("rr_add0_flags", 32'(of_), 32'b001);
        expect_op(0, 1, 2'b11, {16'h00FF, 16'h1234}, {16'h0F0F, 16'h0000}, {OP_XOR, 4'b1010}, od, of_, oe);
        chk("rr_third_data", 32'(od), 32'h0001);

        // Back-pressure on req1 XOR while illegal req0 waits.
        expect_op(5, 1, 2'b11, {16'h00FF, 16'h1234}, {16'h0F0F, 16'h0000}, {OP_XOR, 4'b1010}, od, of_, oe);
        chk("bp_xor_data", 32'(od), 32'h0FF0);
        chk("bp_req0_ready_after", 32'(req_ready), 32'b01);

        // Illegal opcode, then a legal MOVB.
        expect_op(0, 1, 2'b01, 32'd0, {16'h0000, 16'h5555}, {4'd0, OP_MOVB}, od, of_, oe);
        chk("illegal_err", 32'(oe), 1);
        chk("illegal_data", 32'(od), 0);
        chk("illegal_flags", 32'(of_), 0);
        expect_op(0, 1, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);
        chk("movb_err", 32'(oe), 0);
        chk("movb_data", 32'(od), 32'h5555);

        // Asynchronous reset during EXEC, then pointer restart.
        reset_in_exec(1'b1, 16'h0010, OP_INC, "rst_inc");
        reset_in_exec(1'b0, 16'h0101, OP_ADD, "rst_add");
        new_req(1'b0);
        new_req(1'b1);
        req_valid = 2'b11;
        #1;
        chk("rst_ptr_grant", 32'(req_ready), 32'b01);
        expect_op(1, 2, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            if (req_valid == 2'b00) begin
                logic idx;
                idx = 1'($urandom_range(0, 1));
                new_req(idx);
                req_valid[idx] = 1'b1;
            end
            expect_op($urandom_range(0, 3), 2, 2'b00, 32'd0, 32'd0, 8'd0, od, of_, oe);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (opcodes ADD..MOVB, flags {overflow, negative, zero}) between two requesters.
- Per-requester valid/ready request and response handshakes; round-robin grant; registered operands and results.
- Sits between the instruction issue logic and the shared ALU; guarantees one operation in flight.

Parameters:
- BW, 16, datapath bitwidth; must match the attached ALU.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid; bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_a  in  2*BW  operand A; [BW-1:0] = req0, [2*BW-1:BW] = req1
- req_b  in  2*BW  operand B; same packing
- req_opcode  in  8  opcodes; [3:0] = req0, [7:4] = req1
- rsp_valid  out  2  response valid for requester i (one-hot or zero)
- rsp_ready  in  2  requester i takes response
- rsp_data  out  BW  registered ALU result (signed)
- rsp_flags  out  3  registered {overflow, negative, zero}
- rsp_err  out  1  1 = illegal opcode; no ALU result
- alu_a  out  BW  to ALU in_a
- alu_b  out  BW  to ALU in_b
- alu_opcode  out  4  to ALU opcode
- alu_out  in  BW  from ALU out
- alu_flags  in  3  from ALU flags
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (async, any state): state = IDLE; priority pointer = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_opcode, busy.
  - An in-flight operation is dropped with no response.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and asserted only in IDLE, for the granted requester.
  - Grant rules:
    - Only one valid: that requester is granted.
    - Both valid: the requester indicated by the pointer is granted.
  - On the grant edge:
    - Capture a, b, opcode and the grant id into operand registers.
    - Pointer <= ~grant id.
    - Go to EXEC.
  - With no valid requests, remain in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b and alu_opcode are driven from the operand registers; they are stable for the whole cycle and hold their value outside EXEC.
  - At the EXEC edge, for a legal opcode (4'b0000..4'b0111):
    - rsp_data <= alu_out; rsp_flags <= alu_flags; rsp_err <= 0.
  - At the EXEC edge, for an illegal opcode (4'b1000..4'b1111):
    - rsp_data <= 0, rsp_flags <= 0, rsp_err <= 1.
    - alu_opcode is still driven, but its result is ignored.
  - Go to RESP.
- RESP:
  - rsp_valid[grant id] = 1.
  - rsp_data, rsp_flags and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready[grant id] = 1:
    - Go to IDLE.
    - rsp_valid deasserts in the next cycle.
  - rsp_ready of the non-granted requester is ignored.
  - No new request is accepted in RESP.
- Latency: accept at edge N, rsp_valid high from cycle N+2. Minimum 3 cycles per operation (throughput 1 op / 3 clk).
- Requester inputs are sampled only at the accept edge; later changes do not affect the in-flight operation.
- A request held valid without a grant must stay stable; the arbiter never drops it.
- No width extension is performed: result and flags are exactly the ALU's (overflow wraps to BW bits, flagged by flags[2]).
- req_valid deasserted in the same cycle as req_ready: the grant is still taken (ready is combinational from current valid).
- busy = (state != IDLE).

Test Plan:
- Reset, then req0 ADD a=16'h7FFF b=16'h7FFF, rsp_ready=1:
  - req_ready=2'b01 at cycle 0; rsp_valid=2'b01 at cycle 2.
  - rsp_data=16'hFFFE, rsp_flags=3'b110, rsp_err=0.
- Both requesters valid from reset:
  - req0 SUB 16'h8000-16'h7FFF; req1 ADD 0+0.
  - Grant order: req0, req1, then req0 again if still valid.
  - req0 response: data=16'h0001, flags=3'b100.
  - req1 response: data=0, flags=3'b001.
- Back-pressure, req1 XOR 16'h00FF^16'h0F0F:
  - rsp_ready[1] low for 5 cycles: rsp_valid[1] held, rsp_data=16'h0FF0 stable, busy=1.
  - req0 (valid throughout) gets no req_ready until one cycle after rsp_ready[1] rises.
- Illegal opcode 4'b1010 on req0 with a=16'h1234:
  - Response rsp_err=1, rsp_data=0, rsp_flags=0, latency 2 cycles.
  - Next legal request (MOVB b=16'h5555) returns rsp_err=0, data=16'h5555.
- Assert rst asynchronously mid-EXEC of req1 INC a=16'h0010:
  - All outputs 0 immediately; no rsp_valid after release.
  - Pointer reset, so with both valid the first grant is req0.
